instr_encoder_loader: RTL and testbench

- Sequential RV32I instruction encoder and instruction-memory loader; the inverse of the `controller` decode path.
- Accepts decoded instruction fields (format, opcode, rd, rs1, rs2, funct3, funct7, immediate) over a valid/ready stream.
- Packs each into a 32-bit instruction word and writes consecutive words into instruction memory from a programmable base address.
- Used by the bring-up/self-test harness to build programs in IMEM without external hex files.

---
 rtl/instr_encoder_loader.sv | 150 +++++++++++++++
 tb/tb_instr_encoder_loader.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder_loader.sv
// rtl/instr_encoder_loader.sv - RV32I field-bundle encoder that streams packed instructions into IMEM
module instr_encoder_loader #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  num_instr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_fmt,
    input  logic [6:0]        in_opcode,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [31:0]       in_imm,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [CNT_W-1:0]  bad_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DONE
    } state_t;

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] addr_ptr;
    logic [CNT_W-1:0]  remaining;
    logic [31:0]       enc_word;
    logic              enc_bad;
    logic              accept;
    logic              wr_fire;
    logic              fits12;
    logic              fits13;
    logic              fits21;

    // Immediate range checks: all bits above the sign bit must replicate it.
    assign fits12 = (&in_imm[31:11]) | ~(|in_imm[31:11]);
    assign fits13 = (&in_imm[31:12]) | ~(|in_imm[31:12]);
    assign fits21 = (&in_imm[31:20]) | ~(|in_imm[31:20]);

    always_comb begin
        enc_word = NOP_WORD;
        enc_bad  = 1'b0;
        case (in_fmt)
            3'd0: enc_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
            3'd1: begin
                enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
                enc_bad  = ~fits12;
            end
            3'd2: begin
                enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
                enc_bad  = ~fits12;
            end
            3'd3: begin
                enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                            in_imm[4:1], in_imm[11], in_opcode};
                enc_bad  = ~fits13 | in_imm[0];
            end
            3'd4: begin
                enc_word = {in_imm[31:12], in_rd, in_opcode};
                enc_bad  = |in_imm[11:0];
            end
            3'd5: begin
                enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
                enc_bad  = ~fits21 | in_imm[0];
            end
            default: enc_bad = 1'b1;
        endcase
        if (enc_bad) begin
            enc_word = NOP_WORD;
        end
    end

    assign wr_fire  = mem_we & mem_ready;
    assign in_ready = (state == S_LOAD) & (remaining != '0) & (~mem_we | mem_ready);
    assign accept   = in_valid & in_ready;
    assign busy     = (state == S_LOAD);
    assign done     = (state == S_DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = (num_instr != '0) ? S_LOAD : S_DONE;
                end
            end
            S_LOAD: begin
                if ((remaining == '0) && (!mem_we || mem_ready)) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            addr_ptr  <= '0;
            remaining <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            err       <= 1'b0;
            bad_count <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && start) begin
                addr_ptr  <= {base_addr[ADDR_W-1:2], 2'b00};
                remaining <= num_instr;
                err       <= 1'b0;
                bad_count <= '0;
            end
            // A new accept keeps mem_we high through a completing handshake.
            if (accept) begin
                mem_we    <= 1'b1;
                mem_addr  <= addr_ptr;
                mem_wdata <= enc_word;
                addr_ptr  <= addr_ptr + ADDR_W'(4);
                remaining <= remaining - CNT_W'(1);
                if (enc_bad) begin
                    err <= 1'b1;
                    if (bad_count != '1) begin
                        bad_count <= bad_count + CNT_W'(1);
                    end
                end
            end else if (wr_fire) begin
                mem_we <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb/tb_instr_encoder_loader.sv - directed self-checking bench for instr_encoder_loader
module tb_instr_encoder_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] base_addr;
    logic [15:0] num_instr;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_fmt;
    logic [6:0]  in_opcode;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [31:0] in_imm;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] bad_count;

    int checks   = 0;
    int failures = 0;
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];

    instr_encoder_loader #(.ADDR_W(32), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_instr(num_instr),
        .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt), .in_opcode(in_opcode),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3),
        .in_funct7(in_funct7), .in_imm(in_imm), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .busy(busy), .done(done), .err(err),
        .bad_count(bad_count)
    );

    always #5 clk = ~clk;

    // Inputs change only just after posedge, so a negedge view equals the next edge's handshake.
    always @(negedge clk) begin
        if (!rst && mem_we && mem_ready) begin
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_wdata);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [31:0] base, input logic [15:0] num);
        base_addr = base;
        num_instr = num;
        start     = 1'b1;
        step();
        start     = 1'b0;
    endtask

    task automatic send(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] imm);
        bit ok;
        in_fmt = fmt; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_funct3 = f3; in_funct7 = f7; in_imm = imm; in_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
            step();
        end
        if (!ok) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle_input();
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            seen = done;
        end
        check({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
        @(negedge clk);
        check({tag, "_done_one_cycle"}, {31'd0, done}, 32'd0);
        check({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
        step();
    endtask

    task automatic check_writes(input string tag, input logic [31:0] base,
                                input logic [31:0] exp_data[$]);
        check({tag, "_wr_count"}, wr_addr_q.size(), exp_data.size());
        for (int i = 0; i < exp_data.size() && i < wr_addr_q.size(); i++) begin
            check($sformatf("%s_addr%0d", tag, i), wr_addr_q[i], base + 32'(4 * i));
            check($sformatf("%s_data%0d", tag, i), wr_data_q[i], exp_data[i]);
        end
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    initial begin
        logic [31:0] exp[$];
        rst = 1'b1; start = 1'b0; base_addr = '0; num_instr = '0; in_valid = 1'b0;
        in_fmt = '0; in_opcode = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
        in_funct3 = '0; in_funct7 = '0; in_imm = '0; mem_ready = 1'b1;
        step(); step();
        rst = 1'b0;
        @(negedge clk);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_flags", {28'd0, busy, done, err, in_ready}, 32'd0);
        check("rst_bad_count", {16'd0, bad_count}, 32'd0);
        step();

        // 1: ADD then ADDI, consecutive writes, done next cycle
        do_start(32'h100, 16'd2);
        send(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
        send(3'd1, 7'h13, 5'd5, 5'd1, 5'd0, 3'd0, 7'd0, -32'sd8);
        idle_input();
        @(negedge clk);
        check("t1_second_we", {31'd0, mem_we}, 32'd1);
        check("t1_second_data", mem_wdata, 32'hFF80_8293);
        @(negedge clk);
        check("t1_done_next", {31'd0, done}, 32'd1);
        check("t1_busy_in_done", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check("t1_done_clear", {31'd0, done}, 32'd0);
        step();
        exp = '{32'h0020_81B3, 32'hFF80_8293};
        check_writes("t1", 32'h100, exp);

        // 2: S, B, J, U back-to-back
        do_start(32'h203, 16'd4);
        send(3'd2, 7'h23, 5'd0, 5'd1, 5'd7, 3'd2, 7'd0, -32'sd16);
        send(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8);
        send(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd20);
        send(3'd4, 7'h37, 5'd10, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
        idle_input();
        wait_done("t2");
        check("t2_err", {31'd0, err}, 32'd0);
        exp = '{32'hFE70_A823, 32'h0020_8463, 32'h0140_00EF, 32'h1234_5537};
        check_writes("t2", 32'h200, exp);

        // 3: backpressure holds the pending word
        do_start(32'h300, 16'd3);
        mem_ready = 1'b0;
        send(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
        send_hold: begin
            in_fmt = 3'd1; in_opcode = 7'h13; in_rd = 5'd5; in_rs1 = 5'd1; in_imm = -32'sd8;
            in_valid = 1'b1;
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                check($sformatf("t3_stall_we%0d", i), {31'd0, mem_we}, 32'd1);
                check($sformatf("t3_stall_addr%0d", i), mem_addr, 32'h300);
                check($sformatf("t3_stall_data%0d", i), mem_wdata, 32'h0020_81B3);
                check($sformatf("t3_stall_rdy%0d", i), {31'd0, in_ready}, 32'd0);
                step();
            end
        end
        mem_ready = 1'b1;
        send(3'd1, 7'h13, 5'd5, 5'd1, 5'd0, 3'd0, 7'd0, -32'sd8);
        send(3'd4, 7'h37, 5'd10, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
        idle_input();
        wait_done("t3");
        exp = '{32'h0020_81B3, 32'hFF80_8293, 32'h1234_5537};
        check_writes("t3", 32'h300, exp);

        // 4: illegal bundles become NOPs and are counted
        do_start(32'h400, 16'd2);
        send(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd7);
        send(3'd7, 7'h33, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0);
        idle_input();
        wait_done("t4");
        check("t4_err", {31'd0, err}, 32'd1);
        check("t4_bad_count", {16'd0, bad_count}, 32'd2);
        exp = '{32'h0000_0013, 32'h0000_0013};
        check_writes("t4", 32'h400, exp);
        do_start(32'h500, 16'd1);
        check("t4_err_cleared", {31'd0, err}, 32'd0);
        check("t4_bad_cleared", {16'd0, bad_count}, 32'd0);
        send(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
        idle_input();
        wait_done("t4b");
        exp = '{32'h0020_81B3};
        check_writes("t4b", 32'h500, exp);

        // 5: empty session, then start ignored while busy
        do_start(32'h580, 16'd0);
        @(negedge clk);
        check("t5_zero_done", {31'd0, done}, 32'd1);
        check("t5_zero_we", {31'd0, mem_we}, 32'd0);
        @(negedge clk);
        check("t5_zero_done_clr", {31'd0, done}, 32'd0);
        step();
        do_start(32'h600, 16'd2);
        send(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
        idle_input();
        do_start(32'h900, 16'd5);
        send(3'd1, 7'h13, 5'd5, 5'd1, 5'd0, 3'd0, 7'd0, -32'sd8);
        idle_input();
        wait_done("t5");
        exp = '{32'h0020_81B3, 32'hFF80_8293};
        check_writes("t5", 32'h600, exp);

        // 6: reset during a stalled write
        do_start(32'h700, 16'd2);
        mem_ready = 1'b0;
        send(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        check("t6_rst_we", {31'd0, mem_we}, 32'd0);
        check("t6_rst_busy", {31'd0, busy}, 32'd0);
        check("t6_rst_ready", {31'd0, in_ready}, 32'd0);
        step();
        idle_input();
        mem_ready = 1'b1;
        check("t6_no_stale_write", wr_addr_q.size(), 32'd0);
        do_start(32'h800, 16'd1);
        send(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd20);
        idle_input();
        wait_done("t6");
        exp = '{32'h0140_00EF};
        check_writes("t6", 32'h800, exp);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
